dot_seq_feeder: RTL
===================

# dot_seq_feeder

Operand sequencer directly upstream of the 8x8 MAC unit. Buffers up to DEPTH (a, b) byte pairs from a valid/ready load port. On `start` it streams the pairs into the MAC on consecutive cycles, with `mac_enable` high. After the last pair it captures the MAC's 16-bit sum and presents it on a valid/ready result port. It also provides the idle gap the MAC needs to clear its accumulator between dot products.

## Interface
- `DEPTH`, default 8: maximum vector length; power of two, 2..16.
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ld_valid`  in  1: load beat offered.
- `ld_ready`  out  1: beat accepted when both `ld_valid` and `ld_ready` are high.
- `ld_a`, `ld_b`  in  8 each: operand pair for the beat.
- `start`  in  1: single-cycle request to run the loaded vector.
- `busy`  out  1: high whenever state is not IDLE.
- `mac_enable`  out  1: drives the MAC `enable` input.
- `mac_a`, `mac_b`  out  8 each: drive the MAC `a` and `b` inputs.
- `mac_valid`  in  1: the MAC `valid` output.
- `mac_c`  in  16: the MAC `c` output.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_data`  out  16: dot product, modulo 2^16.
- `res_ovf`  out  1: true sum exceeded 16 bits. Functional only with the macro in Configuration.

## Operation
- **State machine:** IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `ld_ready` = (count < DEPTH).
  - Each accepted beat writes the buffer at `wr_ptr` and increments `wr_ptr` and count.
  - `start` with count > 0 goes to RUN with `rd_ptr` = 0.
  - `start` with count = 0 goes directly to DONE with `res_data` = 0 and `res_ovf` = 0. The MAC is never enabled.
  - A beat accepted on the same edge as `start` is part of the vector (count includes it).
- **RUN**
  - `mac_enable` = 1; `mac_a`/`mac_b` = `buf[rd_ptr]`.
  - `rd_ptr` increments every cycle.
  - After count cycles, go to DRAIN.
- **DRAIN**
  - `mac_enable` = 0.
  - On the exiting edge, latch `mac_c` into `res_data` and go to DONE.
  - If `mac_valid` is 0 in DRAIN, set `res_ovf` = 1 (protocol fault).
- **DONE**
  - `res_valid` = 1; `res_data` and `res_ovf` are held stable.
  - When `res_valid` and `res_ready` are both high: clear count and the pointers, go to IDLE.
- **Outside IDLE:** `ld_ready` = 0 and `start` is ignored (not queued).
- **MAC drive in all non-RUN states:** `mac_enable` = 0 and `mac_a`/`mac_b` = 0.
- **Arithmetic:** products are 16 bits and wrap modulo 2^16. The sequencer never alters `mac_c`.
- **Reset**, including mid-RUN or mid-DONE:
  - Next state is IDLE; count, `wr_ptr` and `rd_ptr` = 0.
  - All outputs are 0 except `ld_ready` = 1 (from the IDLE rule once reset is released).
  - Buffer contents are don't-care.
- **Reset during RUN:** `mac_enable` drops, so the MAC clears on the following edge.

## Timing
- Edge 0 is the edge that samples `start` (count = N > 0).
- Edges 1..N: `mac_enable` is high in the cycle before each edge, and pair k-1 is presented before edge k.
- After edge N the state is DRAIN; `mac_c` holds the full sum for that one cycle.
- Edge N+1 latches the result. `res_valid` is high from edge N+1, i.e. N+1 cycles after `start`.
- The MAC sees at least two `enable`-low cycles between runs (DRAIN, plus DONE of at least one cycle). This guarantees its sum is zero before the next RUN.
- Empty start: `res_valid` is high after edge 0.
- Back-to-back: the earliest next `start` is sampled one cycle after the result handshake edge.

## Configuration
- **`DOT_SEQ_OVF_DETECT_EN` defined:**
  - A shadow accumulator of 16 + clog2(DEPTH) bits sums `mac_a` * `mac_b` during RUN.
  - It is cleared on leaving DRAIN and on reset.
  - At DRAIN exit, `res_ovf` = (shadow[MSBs above bit 15] != 0) OR the `mac_valid` fault.
- **Not defined:** no shadow logic; `res_ovf` reflects only the `mac_valid` fault. The port is always present.

## Structure
- **Shared package `dot_seq_pkg`:**
  - State enum (IDLE, RUN, DRAIN, DONE).
  - `OPND_W` = 8 and `RES_W` = 16.
  - A function returning the shadow width for a given DEPTH.
- **Sub-module `dot_seq_operand_buf`:** DEPTH x 16-bit register array with a write port (`wr_en`, `wr_ptr`, data) and combinational read at `rd_ptr`.
- **Top level:** holds the FSM, count and pointers, the result register, and the optional shadow accumulator.

## Test plan
- **Basic dot product:** load (1,2), (3,4), (5,6), then `start`.
  - `mac_enable` is high for exactly 3 cycles with those pairs in order.
  - `res_data` = 44 with `res_valid` 4 cycles after `start`.
  - `res_ovf` = 0.
- **Empty start:** `start` with no loads.
  - `res_valid` next cycle, `res_data` = 0; `mac_enable` never high.
- **Full buffer and wrap (DEPTH = 8):** 9 beats of (255,255).
  - `ld_ready` falls after the 8th beat; the 9th is not accepted.
  - `res_data` = 61448.
  - `res_ovf` = 1 with the macro, 0 without.
- **Result backpressure:** hold `res_ready` low for 5 cycles.
  - `res_valid`/`res_data` stay stable, `ld_ready` = 0, and a `start` pulse is ignored.
  - Raise `res_ready`: IDLE and `ld_ready` = 1 on the next cycle.
- **Reset mid-run:** assert `reset` in the 2nd RUN cycle of a 4-pair vector.
  - Next cycle: `mac_enable` = 0, `busy` = 0, `res_valid` = 0.
  - Then load (2,3) and `start`: `res_data` = 6.
- **Load and start on the same edge:** load (1,1), then present beat (7,7) on the same edge as `start`.
  - Vector length is 2; `res_data` = 50.

Source files
------------

// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot_seq_feeder operand sequencer.
package dot_seq_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shadow accumulator width: enough headroom to sum DEPTH full-scale products.
  function automatic int shadow_w(input int depth);
    return RES_W + $clog2(depth);
  endfunction

endpackage

// File: rtl/dot_seq_operand_buf.sv
// DEPTH-entry operand pair store: {a, b} per entry, synchronous write,
// combinational read. Contents are not reset; the sequencer only reads
// entries it has written since the last result handshake.
module dot_seq_operand_buf
  import dot_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [2*OPND_W-1:0]   wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [2*OPND_W-1:0]   rd_data
);

  logic [2*OPND_W-1:0] mem [DEPTH];

  // Write port: one pair per accepted load beat.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dot_seq_feeder.sv
// Operand sequencer feeding the 8x8 MAC: buffers load beats, streams them
// into the MAC on start, captures the sum and offers it on the result port.
// Optional feature macro: DOT_SEQ_OVF_DETECT_EN adds a shadow accumulator so
// res_ovf also flags sums that exceed 16 bits.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accept load beats, wait for start
// ST_RUN   | present one buffered pair per cycle with mac_enable high
// ST_DRAIN | MAC idle for a cycle; its output holds the full sum, captured here
// ST_DONE  | result held on res_data/res_ovf until res_ready
module dot_seq_feeder
  import dot_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [OPND_W-1:0] ld_a,
  input  logic [OPND_W-1:0] ld_b,
  input  logic              start,
  output logic              busy,
  output logic              mac_enable,
  output logic [OPND_W-1:0] mac_a,
  output logic [OPND_W-1:0] mac_b,
  input  logic              mac_valid,
  input  logic [RES_W-1:0]  mac_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t state, state_next;

  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_inc;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    rd_ptr;
  logic                ld_fire;
  logic [2*OPND_W-1:0] rd_data;
  logic                ovf_calc;

  assign ld_fire   = ld_valid && ld_ready;
  // Vector length as seen by start, including a beat taken on the same edge.
  assign count_inc = count + CNT_W'(ld_fire);

  dot_seq_operand_buf #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (ld_fire),
    .wr_ptr  (wr_ptr),
    .wr_data ({ld_a, ld_b}),
    .rd_ptr  (rd_ptr[PTR_W-1:0]),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    busy       = 1'b1;
    mac_enable = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        ld_ready = (count < CNT_W'(DEPTH));
        if (start) state_next = (count_inc != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        mac_enable = 1'b1;
        mac_a      = rd_data[2*OPND_W-1:OPND_W];
        mac_b      = rd_data[OPND_W-1:0];
        if (rd_ptr == count - CNT_W'(1)) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef DOT_SEQ_OVF_DETECT_EN
  localparam int SH_W = shadow_w(DEPTH);

  logic [SH_W-1:0] shadow;
  logic [SH_W-1:0] prod;

  assign prod = SH_W'(mac_a) * SH_W'(mac_b);

  // Full-precision running sum alongside the MAC, cleared once the result is taken.
  always_ff @(posedge clk) begin
    if (reset)                  shadow <= '0;
    else if (state == ST_RUN)   shadow <= shadow + prod;
    else if (state == ST_DRAIN) shadow <= '0;
  end

  assign ovf_calc = !mac_valid || (shadow[SH_W-1:RES_W] != '0);
`else
  assign ovf_calc = !mac_valid;
`endif

  // Count, pointers and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      res_data <= '0;
      res_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_fire) begin
            count  <= count_inc;
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (start) begin
            rd_ptr <= '0;
            if (count_inc == '0) begin
              res_data <= '0;
              res_ovf  <= 1'b0;
            end
          end
        end
        ST_RUN: rd_ptr <= rd_ptr + CNT_W'(1);
        ST_DRAIN: begin
          res_data <= mac_c;
          res_ovf  <= ovf_calc;
        end
        ST_DONE: begin
          if (res_ready) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
